// File: rtl/regfile_mp_sb_if.sv
// Bundle of read, write, issue and status signals for regfile_mp_sb.
//   master: the datapath side (drives addresses, write data, issue and flush)
//   slave : the register file (returns read data, busy flags and status)
// Port summary:
//   rd_addr/rd_data/rd_busy   NRD packed read ports, port k in slice k
//   wr0_*/wr1_*               two write ports, wr1 has priority
//   iss_en/iss_addr           mark a destination register pending
//   flush                     clear every pending bit
//   iss_conflict/pend_count   registered scoreboard status
interface regfile_mp_sb_if #(
    parameter int DEPTH = 32,
    parameter int ADDR  = 5,
    parameter int WIDTH = 32,
    parameter int NRD   = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [NRD*ADDR-1:0]  rd_addr;
    logic [NRD*WIDTH-1:0] rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 wr0_en;
    logic [ADDR-1:0]      wr0_addr;
    logic [WIDTH-1:0]     wr0_data;
    logic                 wr1_en;
    logic [ADDR-1:0]      wr1_addr;
    logic [WIDTH-1:0]     wr1_data;
    logic                 iss_en;
    logic [ADDR-1:0]      iss_addr;
    logic                 flush;
    logic                 iss_conflict;
    logic [CW-1:0]        pend_count;

    modport master (
        output rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, flush,
        input  rd_data, rd_busy, iss_conflict, pend_count
    );

    modport slave (
        input  rd_addr, wr0_en, wr0_addr, wr0_data, wr1_en, wr1_addr, wr1_data,
               iss_en, iss_addr, flush,
        output rd_data, rd_busy, iss_conflict, pend_count
    );
endinterface

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with a per-register pending scoreboard.
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    regfile_mp_sb_if slave: NRD combinational read ports with busy
//          flags, two write ports (wr1 wins on address collision), issue
//          port that marks a register pending, flush, and registered
//          iss_conflict / pend_count status.
// Addresses >= DEPTH (and address 0 when ZERO_REG=1) are invalid: writes and
// issues to them are dropped and reads from them return data 0, busy 0.
module regfile_mp_sb #(
    parameter int DEPTH    = 32,
    parameter int ADDR     = 5,
    parameter int WIDTH    = 32,
    parameter int NRD      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic            clk,
    input  logic            reset,
    regfile_mp_sb_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [WIDTH-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0]     pend_q, pend_d;
    logic                 iss_conflict_q, iss_conflict_d;
    logic [CW-1:0]        pend_count_q, pend_count_d;
    logic                 wr0_ok, wr1_ok, iss_ok;
    logic [NRD*WIDTH-1:0] rd_data_c;
    logic [NRD-1:0]       rd_busy_c;

    function automatic logic addr_valid(input logic [ADDR-1:0] a);
        addr_valid = (32'(a) < 32'(DEPTH)) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr0_ok = bus.wr0_en & addr_valid(bus.wr0_addr);
    assign wr1_ok = bus.wr1_en & addr_valid(bus.wr1_addr);
    assign iss_ok = bus.iss_en & addr_valid(bus.iss_addr);

    // Next data, pending bits, conflict pulse and population count.
    // Pending priority: flush, then issue (new producer beats a same-cycle
    // writeback), then write clear, then hold.
    always_comb begin : next_state
        iss_conflict_d = 1'b0;
        pend_count_d   = '0;
        pend_d         = pend_q;
        for (int r = 0; r < DEPTH; r++) begin
            mem_d[r] = mem_q[r];
            if (wr1_ok && bus.wr1_addr == ADDR'(r)) begin
                mem_d[r] = bus.wr1_data;
            end else if (wr0_ok && bus.wr0_addr == ADDR'(r)) begin
                mem_d[r] = bus.wr0_data;
            end

            if (bus.flush) begin
                pend_d[r] = 1'b0;
            end else if (iss_ok && bus.iss_addr == ADDR'(r)) begin
                pend_d[r] = 1'b1;
                if (pend_q[r]) begin
                    iss_conflict_d = 1'b1;
                end
            end else if ((wr0_ok && bus.wr0_addr == ADDR'(r)) ||
                         (wr1_ok && bus.wr1_addr == ADDR'(r))) begin
                pend_d[r] = 1'b0;
            end

            pend_count_d = pend_count_d + CW'(pend_d[r]);
        end
    end

    // Combinational read ports with optional same-cycle write forwarding.
    always_comb begin : read_ports
        logic [ADDR-1:0] a;
        rd_data_c = '0;
        rd_busy_c = '0;
        for (int k = 0; k < NRD; k++) begin
            a = bus.rd_addr[k*ADDR +: ADDR];
            if (addr_valid(a)) begin
                for (int r = 0; r < DEPTH; r++) begin
                    if (a == ADDR'(r)) begin
                        rd_data_c[k*WIDTH +: WIDTH] = mem_q[r];
                        rd_busy_c[k]                = pend_q[r];
                    end
                end
                if (BYPASS != 0) begin
                    if (wr1_ok && bus.wr1_addr == a) begin
                        rd_data_c[k*WIDTH +: WIDTH] = bus.wr1_data;
                        rd_busy_c[k]                = 1'b0;
                    end else if (wr0_ok && bus.wr0_addr == a) begin
                        rd_data_c[k*WIDTH +: WIDTH] = bus.wr0_data;
                        rd_busy_c[k]                = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= '0;
            end
            pend_q         <= '0;
            iss_conflict_q <= 1'b0;
            pend_count_q   <= '0;
        end else begin
            for (int r = 0; r < DEPTH; r++) begin
                mem_q[r] <= mem_d[r];
            end
            pend_q         <= pend_d;
            iss_conflict_q <= iss_conflict_d;
            pend_count_q   <= pend_count_d;
        end
    end

    assign bus.rd_data      = rd_data_c;
    assign bus.rd_busy      = rd_busy_c;
    assign bus.iss_conflict = iss_conflict_q;
    assign bus.pend_count   = pend_count_q;
endmodule
